// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Round-robin arbiter that shares the register file's single write port
//   among NREQ writeback sources (ALU result, load return, mul/div unit).
//   Each source uses a valid/ready handshake. The winning write is registered
//   before it drives the regfile, so the write port timing does not depend on
//   requester logic.
//
// Parameters
//   NREQ  number of writeback requesters (2..8)
//   AW    register address width
//   DW    register data width
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous, active-high reset
//   req_valid  in   per-source write request, held until accepted
//   req_ready  out  one-hot accept for the granted source, else 0
//   req_waddr  in   per-source dest register, source i at [i*AW +: AW]
//   req_wdata  in   per-source write data, source i at [i*DW +: DW]
//   rf_we      out  regfile write enable (never asserted for r0)
//   rf_waddr   out  regfile write address
//   rf_wdata   out  regfile write data
//   grant_id   out  source whose write is on rf_* this cycle
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [2:0]        grant_id
);

  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [2:0]    grant_id_q, grant_id_d;

  logic          found;
  logic [2:0]    winner;
  logic [3:0]    idx;
  logic          accept;
  logic [AW-1:0] sel_waddr;
  logic [DW-1:0] sel_wdata;

  // Scan sources starting at rr_ptr, wrapping modulo NREQ; first valid wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the paths that skip it would infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr_q} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && idx[2:0] == 3'(i) && req_valid[i]) begin
          found  = 1'b1;
          winner = 3'(i);
        end
      end
    end
  end

  // Ready is forced low during reset so nothing is handed off while rst=1.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && found && (winner == 3'(i));
    end
  end

  assign accept = found && !rst;

  // Select the winner's address/data with a constant-index mux.
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == 3'(i)) begin
        sel_waddr = req_waddr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Next state: on accept load the write (r0 is accepted but never enabled)
  // and advance the pointer past the winner; otherwise only rf_we drops.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_id_d = grant_id_q;
    if (accept) begin
      rf_we_d    = (sel_waddr != '0);
      rf_waddr_d = sel_waddr;
      rf_wdata_d = sel_wdata;
      grant_id_d = winner;
      rr_ptr_d   = (winner == 3'(NREQ-1)) ? 3'd0 : winner + 3'd1;
    end
  end

  // Asynchronous reset aborts a write currently on rf_* and drops any write
  // accepted in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed bench for rf_wb_arbiter (NREQ=3, AW=5, DW=32). The driver issues
//   one vector per cycle, checks the hand-computed ready pattern and pushes
//   the expected regfile write; a monitor pops and compares whenever rf_we is
//   seen. A small regfile model absorbs the writes for the same-register test.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [2:0]    gid;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [2:0]         grant_id;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [DW-1:0] tb_rf [32];
  logic [AW-1:0] raddr1;

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // Regfile model fed by the arbiter's write port.
  always @(posedge clk) begin
    if (rf_we === 1'b1) tb_rf[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: actual waddr=%0h wdata=%0h gid=%0h expected no write",
                 rf_waddr, rf_wdata, grant_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(e.waddr));
        check("wr_data", rf_wdata, e.wdata);
        check("wr_gid",  32'(grant_id), 32'(e.gid));
      end
    end
  end

  // Drive one cycle of requests, check ready, and queue the expected write
  // of the hand-predicted winner (r0 writes produce no regfile write).
  task automatic issue(input logic [2:0] v, input logic [2:0] exp_rdy,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input string name);
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    a = '{a0, a1, a2};
    d = '{d0, d1, d2};
    @(posedge clk);
    #1;
    req_valid = v;
    req_waddr = {a2, a1, a0};
    req_wdata = {d2, d1, d0};
    @(negedge clk);
    check(name, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i] && a[i] != '0) sb.push_back('{waddr: a[i], wdata: d[i], gid: 3'(i)});
    end
  endtask

  task automatic idle(input string name);
    issue(3'b000, 3'b000, '0, '0, '0, '0, '0, '0, name);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) tb_rf[r] = '0;
    raddr1    = '0;
    rst       = 1'b1;
    req_valid = 3'b111;
    req_waddr = '0;
    req_wdata = '0;

    // Reset values; ready must stay low even with all sources valid.
    repeat (2) @(negedge clk);
    check("rst_we",    32'(rf_we), 0);
    check("rst_waddr", 32'(rf_waddr), 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_gid",   32'(grant_id), 0);
    check("rst_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;

    // Test 1: reset mid-stream. Write 0xAA shows on rf_*, 0xBB is accepted;
    // reset aborts the first and drops the second.
    issue(3'b001, 3'b001, 5'd3, '0, '0, 32'hAA, '0, '0, "t1_accept");
    @(posedge clk);
    #1;
    req_wdata[0 +: DW] = 32'hBB;
    @(negedge clk);
    check("t1_pend_ready", 32'(req_ready), 32'b001);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    #1;
    check("t1_abort_we",    32'(rf_we), 0);
    check("t1_abort_waddr", 32'(rf_waddr), 0);
    check("t1_abort_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) idle("t1_no_stale");

    // Test 3: all valid continuously; pointer must restart at 0 after reset.
    for (int k = 0; k < 6; k++) begin
      logic [2:0] er;
      er = 3'b001 << (k % 3);
      issue(3'b111, er, 5'd1 + 5'(k), 5'd10 + 5'(k), 5'd20 + 5'(k),
            32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k), "t3_grant");
      if (k > 0) check("t3_no_bubble", 32'(rf_we), 1);
    end

    // Test 2: single source, write visible the following cycle.
    issue(3'b010, 3'b010, '0, 5'd5, '0, '0, 32'hDEADBEEF, '0, "t2_ready");
    idle("t2_idle");
    check("t2_we",   32'(rf_we), 1);
    check("t2_addr", 32'(rf_waddr), 5);
    check("t2_data", rf_wdata, 32'hDEADBEEF);
    check("t2_gid",  32'(grant_id), 1);

    // Test 4: r0 write is accepted but not enabled; rf_* fields still update.
    issue(3'b100, 3'b100, '0, '0, 5'd0, '0, '0, 32'h55, "t4_ready");
    idle("t4_idle");
    check("t4_we",   32'(rf_we), 0);
    check("t4_addr", 32'(rf_waddr), 0);
    check("t4_data", rf_wdata, 32'h55);
    check("t4_gid",  32'(grant_id), 2);
    idle("t4_idle2");
    check("hold_data", rf_wdata, 32'h55);
    check("hold_gid",  32'(grant_id), 2);

    // Test 5: pointer back at 0 after the r0 grant; a src0 grant moves it to
    // 1, so with src0 and src2 valid, src2 wins first.
    issue(3'b001, 3'b001, 5'd9, '0, '0, 32'h900, '0, '0, "t5_ptr0");
    issue(3'b101, 3'b100, 5'd10, '0, 5'd12, 32'hA00, '0, 32'hC00, "t5_src2_first");
    issue(3'b001, 3'b001, 5'd10, '0, '0, 32'hA00, '0, '0, "t5_src0_next");
    check("t5_lat_addr", 32'(rf_waddr), 12);
    check("t5_lat_gid",  32'(grant_id), 2);
    idle("t5_idle");
    check("t5_lat2_addr", 32'(rf_waddr), 10);

    // Test 6: back-to-back writes to r7; the later grant wins in the regfile.
    issue(3'b001, 3'b001, 5'd7, '0, '0, 32'h11, '0, '0, "t6_src0");
    issue(3'b010, 3'b010, '0, 5'd7, '0, '0, 32'h22, '0, "t6_src1");
    repeat (2) idle("t6_idle");
    raddr1 = 5'd7;
    check("t6_r7", tb_rf[raddr1], 32'h22);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
